// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, instruction opcodes and the
// sequential controller's state encoding.
package y86_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED,
    S_FAULT
  } seq_state_t;

  function automatic logic is_busy_state(input seq_state_t s);
    return s inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD};
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Synchronous up-counter that sticks at all-ones; clr has priority over inc.
module seq_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ONE;
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Y86 SEQ stage sequencer: one state per stage, status/PC tracking, counters.
// Define SEQ_PERF_CNT_EN to build the busy-cycle counter behind cycle_cnt.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd2,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic [63:0]      new_pc,
  output logic [63:0]      pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_we,
  output logic [2:0]       stat,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  seq_state_t state, next_state;
  stat_t      stat_q, next_stat;
  logic [63:0] next_pc;
  logic       start_clr;
  logic       instr_inc;
  logic       cnt_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      stat_q <= STAT_AOK;
    end else begin
      state  <= next_state;
      pc     <= next_pc;
      stat_q <= next_stat;
    end
  end

  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_stat  = stat_q;
    start_clr  = 1'b0;
    instr_inc  = 1'b0;
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    exec_en    = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    pc_we      = 1'b0;
    case (state)
      S_IDLE, S_HALTED, S_FAULT: begin
        if (start) begin
          next_state = S_FETCH;
          next_pc    = RESET_PC;
          next_stat  = STAT_AOK;
          start_clr  = 1'b1;
        end
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        if (imem_error) begin
          next_state = S_FAULT;
          next_stat  = STAT_ADR;
        end else if (!instr_valid) begin
          next_state = S_FAULT;
          next_stat  = STAT_INS;
        end else if (icode == IHALT) begin
          // halt retires as an instruction even though no later stage runs
          next_state = S_HALTED;
          next_stat  = STAT_HLT;
          instr_inc  = 1'b1;
        end else begin
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en  = 1'b1;
        next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        exec_en    = 1'b1;
        next_state = S_MEMORY;
      end
      S_MEMORY: begin
        mem_en = 1'b1;
        if (dmem_error) begin
          next_state = S_FAULT;
          next_stat  = STAT_ADR;
        end else begin
          next_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        wb_en      = 1'b1;
        next_state = S_PCUPD;
      end
      S_PCUPD: begin
        pc_we      = 1'b1;
        next_pc    = new_pc;
        instr_inc  = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign stat    = stat_q;
  assign busy    = is_busy_state(state);
  assign done    = (state == S_HALTED) || (state == S_FAULT);
  assign cnt_clr = !rst_n || start_clr;

  seq_sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .inc   (instr_inc),
    .count (instr_cnt)
  );

`ifdef SEQ_PERF_CNT_EN
  seq_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .inc   (busy),
    .count (cycle_cnt)
  );
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: doc/seq_stage_ctrl.md
SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd2, start address loaded into pc on reset and on start.
REQ-002 SHALL have parameter CNT_W, default 32, width of instr_cnt and cycle_cnt.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin execution at RESET_PC.
REQ-006 SHALL have port icode, input, 4, fetched opcode from fetch.
REQ-007 SHALL have port instr_valid, input, 1, fetch decoded a legal icode/ifun.
REQ-008 SHALL have port imem_error, input, 1, fetch address out of instruction memory.
REQ-009 SHALL have port dmem_error, input, 1, data-memory access fault.
REQ-010 SHALL have port new_pc, input, 64, next PC from PC-select logic (valP, valC or valM).
REQ-011 SHALL have port pc, output, 64, current PC driven to fetch.
REQ-012 SHALL have ports fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we, output, 1 each, stage strobes.
REQ-013 SHALL have port stat, output, 3, Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-014 SHALL have ports busy and done, output, 1 each, running / terminated.
REQ-015 SHALL have ports instr_cnt and cycle_cnt, output, CNT_W each, retired instructions / active cycles.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED, FAULT, one cycle each.
REQ-017 SHALL assert exactly one strobe per active state: FETCH->fetch_en, DECODE->decode_en, EXECUTE->exec_en, MEMORY->mem_en, WRITEBACK->wb_en, PCUPD->pc_we; none in IDLE/HALTED/FAULT.
REQ-018 SHALL, in IDLE, HALTED or FAULT with start=1, load pc=RESET_PC, stat=AOK, clear instr_cnt and cycle_cnt, enter FETCH.
REQ-019 SHALL ignore start in all other states.
REQ-020 SHALL, in FETCH, use priority imem_error (->FAULT, stat=ADR), then !instr_valid (->FAULT, stat=INS), then icode==0 (->HALTED, stat=HLT, instr_cnt+1), else DECODE.
REQ-021 SHALL advance DECODE->EXECUTE->MEMORY unconditionally.
REQ-022 SHALL, in MEMORY with dmem_error=1, enter FAULT with stat=ADR and never assert wb_en or pc_we for that instruction.
REQ-023 SHALL advance WRITEBACK->PCUPD->FETCH; in PCUPD register pc<=new_pc and instr_cnt+1.
REQ-024 SHALL give normal-instruction latency of exactly 6 cycles, FETCH to next FETCH.
REQ-025 SHALL leave pc unchanged in HALTED and FAULT (PC of the terminating instruction).
REQ-026 SHALL hold busy=1 in FETCH..PCUPD, done=1 in HALTED/FAULT, both 0 in IDLE.
REQ-027 SHALL saturate instr_cnt and cycle_cnt at all-ones; no wrap.
REQ-028 SHALL accept new_pc as 64-bit unsigned; no range check (imem_error on next FETCH covers it).

Reset
REQ-029 SHALL, with rst_n=0 at posedge clk in any state (including mid-instruction), go to IDLE with pc=RESET_PC, stat=AOK, strobes=0, busy=0, done=0, counters=0.
REQ-030 SHALL give rst_n priority over start and all error inputs.

Configuration
REQ-031 SHALL, with SEQ_PERF_CNT_EN defined, increment cycle_cnt every cycle busy=1.
REQ-032 SHALL, without SEQ_PERF_CNT_EN, drive cycle_cnt constant 0 with no counter flops; port list unchanged; instr_cnt always present.

Structure
REQ-033 SHALL take stat codes, icode constants (IHALT=0, INOP=1, ...) and state encoding from shared package y86_pkg.
REQ-034 SHALL instantiate one sub-module seq_sat_counter (parameter CNT_W; clr, inc) for both counters.

Verification
REQ-035 SHALL cover: reset, start, memory 10,20,01 (nop; rrmovq) then 00 -> strobes FETCH..PCUPD twice, pc 2->3->5, HALTED, stat=2, instr_cnt=3.
REQ-036 SHALL cover: imem_error=1 in first FETCH -> FAULT next cycle, stat=3, pc=2, no decode_en.
REQ-037 SHALL cover: instr_valid=0 in FETCH at pc=5 -> FAULT, stat=4, pc=5, done=1.
REQ-038 SHALL cover: dmem_error=1 in MEMORY -> FAULT, stat=3, wb_en and pc_we never asserted, instr_cnt unchanged.
REQ-039 SHALL cover: rst_n=0 during EXECUTE -> IDLE next cycle, pc=2, counters 0; start while busy ignored.
REQ-040 SHALL cover: with SEQ_PERF_CNT_EN, one nop then halt -> cycle_cnt=7; without the macro -> cycle_cnt=0.
